register_renamer: RTL and testbench

Speculative register renamer that sits directly upstream of the physical register file. In decode it maps architectural rs/rd addresses to physical addresses and write-back groups, and allocates a new physical rd from a free list. It frees the superseded mapping at retire and rolls back all un-retired renames after a flush.

---
 rtl/register_renamer.sv | 139 +++++++++++++
 tb/tb_register_renamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_renamer.sv
// Speculative register renamer: combinational arch->phys lookup, free-list allocation in decode,
// in-order release at retire and youngest-first rollback of un-retired renames after a flush.
module register_renamer #(
  parameter int NUM_ARCH     = 32,
  parameter int DEPTH        = 64,
  parameter int WB_GROUPS    = 2,
  parameter int MAX_INFLIGHT = 32,
  localparam int AW = $clog2(NUM_ARCH),
  localparam int PW = $clog2(DEPTH),
  localparam int GW = (WB_GROUPS > 1) ? $clog2(WB_GROUPS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] decode_rs_addr [2],
  input  logic [AW-1:0] decode_rd_addr,
  input  logic          decode_uses_rd,
  input  logic [GW-1:0] decode_rd_wb_group,
  input  logic          decode_advance,
  output logic [PW-1:0] decode_phys_rs_addr [2],
  output logic [GW-1:0] decode_rs_wb_group [2],
  output logic [PW-1:0] decode_phys_rd_addr,
  output logic          rename_ready,
  input  logic          retire_valid,
  input  logic          flush,
  output logic          rollback_busy
);
  localparam int FLD = DEPTH - NUM_ARCH;
  localparam int FLW = (FLD > 1) ? $clog2(FLD) : 1;
  localparam int RW  = $clog2(MAX_INFLIGHT);
  localparam logic [FLW:0] FL_FULL  = (FLW+1)'(FLD);
  localparam logic [RW:0]  REC_FULL = (RW+1)'(MAX_INFLIGHT);
  localparam logic [RW:0]  REC_ONE  = (RW+1)'(1);

  typedef enum logic [1:0] {INIT, NORMAL, ROLLBACK} state_t;
  state_t state;
  logic [AW-1:0] k;

  logic [PW-1:0] map_phys [NUM_ARCH];
  logic [GW-1:0] map_grp  [NUM_ARCH];

  logic [PW-1:0]  fl [FLD];
  logic [FLW-1:0] fl_head, fl_tail, rb_slot;
  logic [FLW:0]   fl_cnt;

  logic [AW-1:0] rec_rd      [MAX_INFLIGHT];
  logic [PW-1:0] rec_old     [MAX_INFLIGHT];
  logic [GW-1:0] rec_old_grp [MAX_INFLIGHT];
  logic [PW-1:0] rec_new     [MAX_INFLIGHT];
  logic [RW-1:0] rec_head, rec_tail, rec_last;
  logic [RW:0]   rec_cnt, rec_cnt_nxt;

  logic alloc, ret, rb;

  function automatic logic [FLW-1:0] fl_inc(input logic [FLW-1:0] p);
    return (p == FLW'(FLD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rename_ready  = (state == NORMAL) && (fl_cnt != '0) && (rec_cnt != REC_FULL) && !flush;
  assign rollback_busy = (state == ROLLBACK);
  assign alloc = decode_advance && rename_ready && decode_uses_rd && (decode_rd_addr != '0);
  assign ret   = retire_valid && (rec_cnt != '0) && (state != INIT);
  // With a single record left, a concurrent retire consumes it and the tail pop is skipped.
  assign rb    = (state == ROLLBACK) && !(ret && rec_cnt == REC_ONE);

  assign rec_last    = rec_tail - 1'b1;
  assign rb_slot     = ret ? fl_inc(fl_tail) : fl_tail;
  assign rec_cnt_nxt = rec_cnt + (RW+1)'(alloc) - (RW+1)'(ret) - (RW+1)'(rb);

  assign decode_phys_rd_addr = alloc ? fl[fl_head] : '0;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      decode_phys_rs_addr[i] = '0;
      decode_rs_wb_group[i]  = '0;
      if (state != INIT) begin
        decode_phys_rs_addr[i] = map_phys[decode_rs_addr[i]];
        decode_rs_wb_group[i]  = map_grp[decode_rs_addr[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      map_phys[k]   <= PW'(k);
      map_grp[k]    <= '0;
      fl[FLW'(k)]   <= PW'(NUM_ARCH) + PW'(k);
    end else begin
      if (alloc) begin
        map_phys[decode_rd_addr] <= fl[fl_head];
        map_grp[decode_rd_addr]  <= decode_rd_wb_group;
        rec_rd[rec_tail]         <= decode_rd_addr;
        rec_old[rec_tail]        <= map_phys[decode_rd_addr];
        rec_old_grp[rec_tail]    <= map_grp[decode_rd_addr];
        rec_new[rec_tail]        <= fl[fl_head];
      end
      if (rb) begin
        map_phys[rec_rd[rec_last]] <= rec_old[rec_last];
        map_grp[rec_rd[rec_last]]  <= rec_old_grp[rec_last];
        fl[rb_slot]                <= rec_new[rec_last];
      end
      if (ret) fl[fl_tail] <= rec_old[rec_head];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      k        <= '0;
      fl_head  <= '0;
      fl_tail  <= '0;
      fl_cnt   <= '0;
      rec_head <= '0;
      rec_tail <= '0;
      rec_cnt  <= '0;
    end else begin
      case (state)
        INIT: begin
          k <= k + 1'b1;
          if (k == AW'(NUM_ARCH - 1)) begin
            state  <= NORMAL;
            fl_cnt <= FL_FULL;
          end
        end
        default: begin
          if (alloc) fl_head <= fl_inc(fl_head);
          if (ret && rb) fl_tail <= fl_inc(fl_inc(fl_tail));
          else if (ret || rb) fl_tail <= fl_inc(fl_tail);
          fl_cnt <= fl_cnt + (FLW+1)'(ret) + (FLW+1)'(rb) - (FLW+1)'(alloc);
          if (ret) rec_head <= rec_head + 1'b1;
          if (alloc) rec_tail <= rec_tail + 1'b1;
          else if (rb) rec_tail <= rec_last;
          rec_cnt <= rec_cnt_nxt;
          if (state == NORMAL && flush && rec_cnt_nxt != '0) state <= ROLLBACK;
          else if (state == ROLLBACK && rec_cnt_nxt == '0) state <= NORMAL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_register_renamer.sv
// Bench for register_renamer: scenario tasks with an expected-phys_rd queue filled at drive time.
module tb_register_renamer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs_addr [2];
  logic [4:0] rd_addr;
  logic       uses_rd;
  logic [0:0] rd_grp;
  logic       advance;
  logic [5:0] phys_rs [2];
  logic [0:0] rs_grp [2];
  logic [5:0] phys_rd;
  logic       ready;
  logic       retire_valid;
  logic       flush;
  logic       busy;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  register_renamer dut (
    .clk(clk), .rst(rst),
    .decode_rs_addr(rs_addr), .decode_rd_addr(rd_addr), .decode_uses_rd(uses_rd),
    .decode_rd_wb_group(rd_grp), .decode_advance(advance),
    .decode_phys_rs_addr(phys_rs), .decode_rs_wb_group(rs_grp), .decode_phys_rd_addr(phys_rd),
    .rename_ready(ready), .retire_valid(retire_valid), .flush(flush), .rollback_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic adv, input logic use_rd, input logic [4:0] rd, input logic g,
                       input logic ret, input logic fl, input logic [4:0] rs0, input logic [4:0] rs1);
    @(negedge clk);
    advance = adv; uses_rd = use_rd; rd_addr = rd; rd_grp = g;
    retire_valid = ret; flush = fl; rs_addr[0] = rs0; rs_addr[1] = rs1;
    #1;
  endtask

  task automatic idle(input logic [4:0] rs0, input logic [4:0] rs1);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rs0, rs1);
  endtask

  task automatic rename(input logic [4:0] rd, input logic g, input int want);
    exp_q.push_back(want);
    drive(1'b1, 1'b1, rd, g, 1'b0, 1'b0, rd, 5'd0);
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst = 1'b0; advance = 1'b0; uses_rd = 1'b0; rd_addr = 5'd0; rd_grp = 1'b0;
    retire_valid = 1'b0; flush = 1'b0; rs_addr[0] = 5'd5; rs_addr[1] = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (phys_rs[0] !== 6'd0) begin bad++; $display("FAIL init_rs_forced got=%0d want=0", phys_rs[0]); end
    while (ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    total++; if (n != 32) begin bad++; $display("FAIL init_len got=%0d want=32", n); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; advance = 1'b1; uses_rd = 1'b1; rd_addr = 5'd5; rd_grp = 1'b1;
    retire_valid = 1'b0; flush = 1'b0; rs_addr[0] = 5'd5; rs_addr[1] = 5'd7;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (phys_rd !== 6'd0) begin bad++; $display("FAIL rst_phys_rd got=%0d want=0", phys_rd); end
    do_reset();
    idle(5'd5, 5'd7);
    total++; if (phys_rs[0] !== 6'd5) begin bad++; $display("FAIL ident_rs0 got=%0d want=5", phys_rs[0]); end
    total++; if (rs_grp[0] !== 1'b0) begin bad++; $display("FAIL ident_grp got=%0d want=0", rs_grp[0]); end
    total++; if (phys_rs[1] !== 6'd7) begin bad++; $display("FAIL ident_rs1 got=%0d want=7", phys_rs[1]); end
  endtask

  task automatic test_rename_basic();
    int want;
    rename(5'd5, 1'b1, 32);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL basic_rd got=%0d want=%0d", phys_rd, want); end
    total++; if (phys_rs[0] !== 6'd5) begin bad++; $display("FAIL same_cycle_rs got=%0d want=5", phys_rs[0]); end
    idle(5'd5, 5'd0);
    total++; if (phys_rs[0] !== 6'd32) begin bad++; $display("FAIL next_cycle_rs got=%0d want=32", phys_rs[0]); end
    total++; if (rs_grp[0] !== 1'b1) begin bad++; $display("FAIL next_cycle_grp got=%0d want=1", rs_grp[0]); end
  endtask

  task automatic test_fill_retire();
    int want;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rename(5'((i % 31) + 1), 1'(i), 32 + i);
      want = exp_q.pop_front(); total++;
      if (phys_rd !== 6'(want)) begin bad++; $display("FAIL fill_rd[%0d] got=%0d want=%0d", i, phys_rd, want); end
    end
    exp_q.push_back(0);
    drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready); end
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL full_rd got=%0d want=%0d", phys_rd, want); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL retire_ready got=%b want=1", ready); end
    rename(5'd9, 1'b0, 1);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL reuse_rd got=%0d want=%0d", phys_rd, want); end
  endtask

  task automatic test_flush_rollback();
    int want;
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rename(5'(i == 1 ? 2 : 1), 1'(i), 32 + i);
      want = exp_q.pop_front(); total++;
      if (phys_rd !== 6'(want)) begin bad++; $display("FAIL fl_rd[%0d] got=%0d want=%0d", i, phys_rd, want); end
    end
    exp_q.push_back(0);
    drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL flush_suppress got=%0d want=%0d", phys_rd, want); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", ready); end
    idle(5'd1, 5'd2);
    while (busy === 1'b1 && n < 50) begin n++; idle(5'd1, 5'd2); end
    total++; if (n != 3) begin bad++; $display("FAIL rb_len got=%0d want=3", n); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rb_ready got=%b want=1", ready); end
    total++; if (phys_rs[0] !== 6'd1) begin bad++; $display("FAIL rb_x1 got=%0d want=1", phys_rs[0]); end
    total++; if (phys_rs[1] !== 6'd2) begin bad++; $display("FAIL rb_x2 got=%0d want=2", phys_rs[1]); end
    rename(5'd4, 1'b0, 35);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rb_next_rd got=%0d want=%0d", phys_rd, want); end
  endtask

  task automatic test_no_alloc();
    int want;
    int n = 0;
    do_reset();
    exp_q.push_back(0);
    drive(1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL no_use_rd got=%0d want=%0d", phys_rd, want); end
    exp_q.push_back(0);
    drive(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rd_zero got=%0d want=%0d", phys_rd, want); end
    idle(5'd7, 5'd0);
    total++; if (phys_rs[0] !== 6'd7) begin bad++; $display("FAIL no_alloc_x7 got=%0d want=7", phys_rs[0]); end
    total++; if (phys_rs[1] !== 6'd0) begin bad++; $display("FAIL no_alloc_x0 got=%0d want=0", phys_rs[1]); end
    rename(5'd7, 1'b0, 32);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL no_alloc_next got=%0d want=%0d", phys_rd, want); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    while (busy === 1'b1 && n < 50) begin n++; idle(5'd7, 5'd0); end
    total++; if (n != 1) begin bad++; $display("FAIL no_alloc_rb_len got=%0d want=1", n); end
  endtask

  task automatic test_retire_rollback();
    int want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rename(5'(i + 1), 1'(i == 0), 32 + i);
      want = exp_q.pop_front(); total++;
      if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rr_rd[%0d] got=%0d want=%0d", i, phys_rd, want); end
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy1 got=%b want=1", busy); end
    idle(5'd1, 5'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy2 got=%b want=1", busy); end
    idle(5'd1, 5'd2);
    total++; if (busy !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL rr_done got=%b%b want=01", busy, ready); end
    total++; if (phys_rs[0] !== 6'd32 || rs_grp[0] !== 1'b1) begin bad++; $display("FAIL rr_x1 got=%0d/%0d want=32/1", phys_rs[0], rs_grp[0]); end
    total++; if (phys_rs[1] !== 6'd2) begin bad++; $display("FAIL rr_x2 got=%0d want=2", phys_rs[1]); end
    for (int i = 0; i < 32; i++) begin
      rename(5'((i % 31) + 1), 1'b0, (i < 29) ? 35 + i : (i == 29) ? 1 : (i == 30) ? 34 : 33);
      want = exp_q.pop_front(); total++;
      if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rr_wrap[%0d] got=%0d want=%0d", i, phys_rd, want); end
    end
  endtask

  task automatic test_retire_wins();
    int want;
    do_reset();
    rename(5'd4, 1'b1, 32);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rw_rd got=%0d want=%0d", phys_rd, want); end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy got=%b want=1", busy); end
    idle(5'd4, 5'd0);
    total++; if (busy !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL rw_done got=%b%b want=01", busy, ready); end
    total++; if (phys_rs[0] !== 6'd32 || rs_grp[0] !== 1'b1) begin bad++; $display("FAIL rw_x4 got=%0d/%0d want=32/1", phys_rs[0], rs_grp[0]); end
    rename(5'd5, 1'b0, 33);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL rw_next_rd got=%0d want=%0d", phys_rd, want); end
  endtask

  task automatic test_reset_mid_rollback();
    int want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rename(5'(i + 1), 1'b1, 32 + i);
      want = exp_q.pop_front(); total++;
      if (phys_rd !== 6'(want)) begin bad++; $display("FAIL mr_rd[%0d] got=%0d want=%0d", i, phys_rd, want); end
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2);
    idle(5'd1, 5'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mr_busy got=%b want=1", busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL mr_rst got=%b%b want=00", busy, ready); end
    do_reset();
    idle(5'd1, 5'd3);
    total++; if (phys_rs[0] !== 6'd1 || rs_grp[0] !== 1'b0) begin bad++; $display("FAIL mr_x1 got=%0d/%0d want=1/0", phys_rs[0], rs_grp[0]); end
    total++; if (phys_rs[1] !== 6'd3) begin bad++; $display("FAIL mr_x3 got=%0d want=3", phys_rs[1]); end
    rename(5'd1, 1'b0, 32);
    want = exp_q.pop_front(); total++;
    if (phys_rd !== 6'(want)) begin bad++; $display("FAIL mr_next_rd got=%0d want=%0d", phys_rd, want); end
  endtask

  initial begin
    advance = 1'b0; uses_rd = 1'b0; rd_addr = 5'd0; rd_grp = 1'b0;
    retire_valid = 1'b0; flush = 1'b0; rs_addr[0] = 5'd0; rs_addr[1] = 5'd0;
    test_reset();
    test_rename_basic();
    test_fill_retire();
    test_flush_rollback();
    test_no_alloc();
    test_retire_rollback();
    test_retire_wins();
    test_reset_mid_rollback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end
endmodule
